// File: rtl/axis_width_adapter.sv
// AXI4-Stream width adapter: packs narrow beats into wide ones or splits wide beats into narrow ones.
// Optional tid/tdest sideband ports are enabled by defining AXIS_WIDTH_ADAPTER_ID_DEST_EN.
module axis_width_adapter #(
    parameter int S_DATA_WIDTH  = 8,
    parameter bit S_KEEP_ENABLE = (S_DATA_WIDTH > 8),
    parameter int S_KEEP_WIDTH  = S_DATA_WIDTH / 8,
    parameter int M_DATA_WIDTH  = 8,
    parameter bit M_KEEP_ENABLE = (M_DATA_WIDTH > 8),
    parameter int M_KEEP_WIDTH  = M_DATA_WIDTH / 8,
    parameter bit USER_ENABLE   = 1'b1,
    parameter int USER_WIDTH    = 1,
    parameter int ID_WIDTH      = 8,
    parameter int DEST_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
    input  logic [ID_WIDTH-1:0]     s_axis_tid,
    input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
    output logic [ID_WIDTH-1:0]     m_axis_tid,
    output logic [DEST_WIDTH-1:0]   m_axis_tdest,
`endif
    output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_tuser
);

    if ((S_DATA_WIDTH % S_KEEP_WIDTH) != 0 || (M_DATA_WIDTH % M_KEEP_WIDTH) != 0) begin : g_err_div
        $fatal(1, "axis_width_adapter: data width is not a multiple of its lane count");
    end
    if ((S_DATA_WIDTH / S_KEEP_WIDTH) != (M_DATA_WIDTH / M_KEEP_WIDTH)) begin : g_err_lane
        $fatal(1, "axis_width_adapter: input and output lane sizes differ");
    end
    if ((M_KEEP_WIDTH % S_KEEP_WIDTH) != 0 && (S_KEEP_WIDTH % M_KEEP_WIDTH) != 0) begin : g_err_ratio
        $fatal(1, "axis_width_adapter: lane counts are not integer multiples");
    end

    logic [S_KEEP_WIDTH-1:0] s_keep;
    logic [USER_WIDTH-1:0]   s_user;
    logic [M_KEEP_WIDTH-1:0] m_keep_i;
    logic [USER_WIDTH-1:0]   m_user_i;

    assign s_keep       = S_KEEP_ENABLE ? s_axis_tkeep : '1;
    assign s_user       = USER_ENABLE ? s_axis_tuser : '0;
    assign m_axis_tkeep = M_KEEP_ENABLE ? m_keep_i : '1;
    assign m_axis_tuser = USER_ENABLE ? m_user_i : '0;

    // Inputs/internal values that some parameter sets legitimately ignore.
    logic unused_sink;
    assign unused_sink = ^{s_axis_tkeep, s_axis_tuser, m_keep_i, m_user_i};
`ifndef AXIS_WIDTH_ADAPTER_ID_DEST_EN
    localparam int unused_id_dest = ID_WIDTH + DEST_WIDTH;
`endif

    if (M_KEEP_WIDTH == S_KEEP_WIDTH) begin : g_pass
        assign m_axis_tdata  = s_axis_tdata;
        assign m_keep_i      = s_keep;
        assign m_axis_tvalid = s_axis_tvalid;
        assign s_axis_tready = m_axis_tready;
        assign m_axis_tlast  = s_axis_tlast;
        assign m_user_i      = s_user;
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
        assign m_axis_tid    = s_axis_tid;
        assign m_axis_tdest  = s_axis_tdest;
`endif
    end else if (M_KEEP_WIDTH > S_KEEP_WIDTH) begin : g_up
        localparam int R  = M_KEEP_WIDTH / S_KEEP_WIDTH;
        localparam int CW = $clog2(R);

        logic [CW-1:0]           cnt;
        logic [M_DATA_WIDTH-1:0] acc_data, nxt_data, out_data;
        logic [M_KEEP_WIDTH-1:0] acc_keep, nxt_keep, out_keep;
        logic                    out_valid, out_last;
        logic [USER_WIDTH-1:0]   out_user;
        logic                    fin, ready, xfer;

        // Only a group-completing segment needs the output register.
        assign fin   = (cnt == CW'(R - 1)) || s_axis_tlast;
        assign ready = !out_valid || m_axis_tready || !fin;
        assign xfer  = s_axis_tvalid && ready;

        always_comb begin
            nxt_data = acc_data;
            nxt_keep = acc_keep;
            for (int k = 0; k < R; k++) begin
                if (cnt == CW'(k)) begin
                    nxt_data[k*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata;
                    nxt_keep[k*S_KEEP_WIDTH +: S_KEEP_WIDTH] = s_keep;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt       <= '0;
                acc_data  <= '0;
                acc_keep  <= '0;
                out_data  <= '0;
                out_keep  <= '0;
                out_last  <= 1'b0;
                out_user  <= '0;
                out_valid <= 1'b0;
            end else begin
                if (out_valid && m_axis_tready)
                    out_valid <= 1'b0;
                if (xfer) begin
                    if (fin) begin
                        out_data  <= nxt_data;
                        out_keep  <= nxt_keep;
                        out_last  <= s_axis_tlast;
                        out_user  <= s_user;
                        out_valid <= 1'b1;
                        acc_data  <= '0;
                        acc_keep  <= '0;
                        cnt       <= '0;
                    end else begin
                        acc_data  <= nxt_data;
                        acc_keep  <= nxt_keep;
                        cnt       <= cnt + CW'(1);
                    end
                end
            end
        end

`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
        // Sideband follows the first segment of the group.
        logic [ID_WIDTH-1:0]   id_q, out_id;
        logic [DEST_WIDTH-1:0] dest_q, out_dest;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                id_q     <= '0;
                dest_q   <= '0;
                out_id   <= '0;
                out_dest <= '0;
            end else if (xfer) begin
                if (cnt == '0) begin
                    id_q   <= s_axis_tid;
                    dest_q <= s_axis_tdest;
                end
                if (fin) begin
                    out_id   <= (cnt == '0) ? s_axis_tid : id_q;
                    out_dest <= (cnt == '0) ? s_axis_tdest : dest_q;
                end
            end
        end
        assign m_axis_tid   = out_id;
        assign m_axis_tdest = out_dest;
`endif

        assign s_axis_tready = ready;
        assign m_axis_tdata  = out_data;
        assign m_keep_i      = out_keep;
        assign m_axis_tvalid = out_valid;
        assign m_axis_tlast  = out_last;
        assign m_user_i      = out_user;
    end else begin : g_down
        localparam int R  = S_KEEP_WIDTH / M_KEEP_WIDTH;
        localparam int CW = $clog2(R);

        logic [S_DATA_WIDTH-1:0] hold_data;
        logic [S_KEEP_WIDTH-1:0] hold_keep;
        logic                    hold_valid, hold_last;
        logic [USER_WIDTH-1:0]   hold_user;
        logic [CW-1:0]           idx, top, in_top;
        logic                    in_any, final_seg, ready, xfer;

        // Highest segment of the incoming word that carries any lane.
        always_comb begin
            in_top = '0;
            for (int k = 0; k < R; k++)
                if (|s_keep[k*M_KEEP_WIDTH +: M_KEEP_WIDTH])
                    in_top = CW'(k);
        end

        assign in_any    = |s_keep;
        assign final_seg = (idx == top);
        assign ready     = !hold_valid || (m_axis_tready && final_seg);
        assign xfer      = s_axis_tvalid && ready;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                hold_valid <= 1'b0;
                hold_data  <= '0;
                hold_keep  <= '0;
                hold_last  <= 1'b0;
                hold_user  <= '0;
                idx        <= '0;
                top        <= '0;
            end else begin
                if (hold_valid && m_axis_tready) begin
                    if (final_seg) begin
                        hold_valid <= 1'b0;
                        idx        <= '0;
                    end else begin
                        idx <= idx + CW'(1);
                    end
                end
                // Empty non-final words are swallowed; an empty final word still carries tlast.
                if (xfer && (in_any || s_axis_tlast)) begin
                    hold_valid <= 1'b1;
                    hold_data  <= s_axis_tdata;
                    hold_keep  <= s_keep;
                    hold_last  <= s_axis_tlast;
                    hold_user  <= s_user;
                    idx        <= '0;
                    top        <= in_top;
                end
            end
        end

        always_comb begin
            m_axis_tdata = '0;
            m_keep_i     = '0;
            for (int k = 0; k < R; k++) begin
                if (idx == CW'(k)) begin
                    m_axis_tdata = hold_data[k*M_DATA_WIDTH +: M_DATA_WIDTH];
                    m_keep_i     = hold_keep[k*M_KEEP_WIDTH +: M_KEEP_WIDTH];
                end
            end
        end

`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
        logic [ID_WIDTH-1:0]   hold_id;
        logic [DEST_WIDTH-1:0] hold_dest;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                hold_id   <= '0;
                hold_dest <= '0;
            end else if (xfer && (in_any || s_axis_tlast)) begin
                hold_id   <= s_axis_tid;
                hold_dest <= s_axis_tdest;
            end
        end
        assign m_axis_tid   = hold_id;
        assign m_axis_tdest = hold_dest;
`endif

        assign s_axis_tready = ready;
        assign m_axis_tvalid = hold_valid;
        assign m_axis_tlast  = hold_last && final_seg;
        assign m_user_i      = hold_user;
    end

endmodule

// File: tb/tb_axis_width_adapter.sv
// Scoreboard bench for axis_width_adapter: upsize 8->32, downsize 32->8, pass-through 64->64,
// and an 8->16 sideband check when AXIS_WIDTH_ADAPTER_ID_DEST_EN is defined.
module tb_axis_width_adapter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [1:0]  user;
    } beat_t;

    beat_t up_q[$], dn_q[$], eq_q[$];
    beat_t up_e, dn_e, eq_e;

    // ---------------- upsize 8 -> 32
    logic [7:0]  up_s_data;
    logic [0:0]  up_s_keep, up_s_user, up_m_user;
    logic        up_s_valid, up_s_ready, up_s_last;
    logic [31:0] up_m_data;
    logic [3:0]  up_m_keep;
    logic        up_m_valid, up_m_ready, up_m_last;
    // ---------------- downsize 32 -> 8
    logic [31:0] dn_s_data;
    logic [3:0]  dn_s_keep;
    logic [0:0]  dn_s_user, dn_m_user, dn_m_keep;
    logic        dn_s_valid, dn_s_ready, dn_s_last;
    logic [7:0]  dn_m_data;
    logic        dn_m_valid, dn_m_ready, dn_m_last;
    // ---------------- pass-through 64 -> 64
    logic [63:0] eq_s_data, eq_m_data;
    logic [7:0]  eq_s_keep, eq_m_keep;
    logic [1:0]  eq_s_user, eq_m_user;
    logic        eq_s_valid, eq_s_ready, eq_s_last;
    logic        eq_m_valid, eq_m_ready, eq_m_last;

`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
    logic [7:0]  up_m_tid, up_m_tdest, dn_m_tid, dn_m_tdest, eq_m_tid, eq_m_tdest;
    logic [7:0]  id_s_data, id_s_tid, id_s_tdest, id_m_tid, id_m_tdest;
    logic [15:0] id_m_data;
    logic [1:0]  id_m_keep;
    logic [0:0]  id_s_keep, id_s_user, id_m_user;
    logic        id_s_valid, id_s_ready, id_s_last, id_m_valid, id_m_ready, id_m_last;
`endif

    axis_width_adapter #(.S_DATA_WIDTH(8), .M_DATA_WIDTH(32)) u_up (
        .clk(clk), .rst(rst),
        .s_axis_tdata(up_s_data), .s_axis_tkeep(up_s_keep), .s_axis_tvalid(up_s_valid),
        .s_axis_tready(up_s_ready), .s_axis_tlast(up_s_last), .s_axis_tuser(up_s_user),
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
        .s_axis_tid(8'd0), .s_axis_tdest(8'd0), .m_axis_tid(up_m_tid), .m_axis_tdest(up_m_tdest),
`endif
        .m_axis_tdata(up_m_data), .m_axis_tkeep(up_m_keep), .m_axis_tvalid(up_m_valid),
        .m_axis_tready(up_m_ready), .m_axis_tlast(up_m_last), .m_axis_tuser(up_m_user)
    );

    axis_width_adapter #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(8), .M_KEEP_ENABLE(1'b1)) u_dn (
        .clk(clk), .rst(rst),
        .s_axis_tdata(dn_s_data), .s_axis_tkeep(dn_s_keep), .s_axis_tvalid(dn_s_valid),
        .s_axis_tready(dn_s_ready), .s_axis_tlast(dn_s_last), .s_axis_tuser(dn_s_user),
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
        .s_axis_tid(8'd0), .s_axis_tdest(8'd0), .m_axis_tid(dn_m_tid), .m_axis_tdest(dn_m_tdest),
`endif
        .m_axis_tdata(dn_m_data), .m_axis_tkeep(dn_m_keep), .m_axis_tvalid(dn_m_valid),
        .m_axis_tready(dn_m_ready), .m_axis_tlast(dn_m_last), .m_axis_tuser(dn_m_user)
    );

    axis_width_adapter #(.S_DATA_WIDTH(64), .M_DATA_WIDTH(64), .USER_WIDTH(2)) u_eq (
        .clk(clk), .rst(rst),
        .s_axis_tdata(eq_s_data), .s_axis_tkeep(eq_s_keep), .s_axis_tvalid(eq_s_valid),
        .s_axis_tready(eq_s_ready), .s_axis_tlast(eq_s_last), .s_axis_tuser(eq_s_user),
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
        .s_axis_tid(8'd0), .s_axis_tdest(8'd0), .m_axis_tid(eq_m_tid), .m_axis_tdest(eq_m_tdest),
`endif
        .m_axis_tdata(eq_m_data), .m_axis_tkeep(eq_m_keep), .m_axis_tvalid(eq_m_valid),
        .m_axis_tready(eq_m_ready), .m_axis_tlast(eq_m_last), .m_axis_tuser(eq_m_user)
    );

`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
    axis_width_adapter #(.S_DATA_WIDTH(8), .M_DATA_WIDTH(16)) u_id (
        .clk(clk), .rst(rst),
        .s_axis_tdata(id_s_data), .s_axis_tkeep(id_s_keep), .s_axis_tvalid(id_s_valid),
        .s_axis_tready(id_s_ready), .s_axis_tlast(id_s_last), .s_axis_tuser(id_s_user),
        .s_axis_tid(id_s_tid), .s_axis_tdest(id_s_tdest), .m_axis_tid(id_m_tid), .m_axis_tdest(id_m_tdest),
        .m_axis_tdata(id_m_data), .m_axis_tkeep(id_m_keep), .m_axis_tvalid(id_m_valid),
        .m_axis_tready(id_m_ready), .m_axis_tlast(id_m_last), .m_axis_tuser(id_m_user)
    );
`endif

    // ---------------- output monitors (sampled on the falling edge)
    always @(negedge clk) begin
        if (rst && up_m_valid && up_m_ready) begin
            if (up_q.size() == 0) chk("up_extra_beat", 64'h1, 64'h0);
            else begin
                up_e = up_q.pop_front();
                chk("up_data", 64'(up_m_data), 64'(up_e.data[31:0]));
                chk("up_keep", 64'(up_m_keep), 64'(up_e.keep[3:0]));
                chk("up_last", 64'(up_m_last), 64'(up_e.last));
                chk("up_user", 64'(up_m_user), 64'(up_e.user[0]));
            end
        end
        if (rst && dn_m_valid && dn_m_ready) begin
            if (dn_q.size() == 0) chk("dn_extra_beat", 64'h1, 64'h0);
            else begin
                dn_e = dn_q.pop_front();
                chk("dn_data", 64'(dn_m_data), 64'(dn_e.data[7:0]));
                chk("dn_keep", 64'(dn_m_keep), 64'(dn_e.keep[0]));
                chk("dn_last", 64'(dn_m_last), 64'(dn_e.last));
                chk("dn_user", 64'(dn_m_user), 64'(dn_e.user[0]));
            end
        end
        if (rst) begin
            chk("eq_valid_timing", 64'(eq_m_valid), 64'(eq_s_valid));
            chk("eq_ready_timing", 64'(eq_s_ready), 64'(eq_m_ready));
        end
        if (rst && eq_m_valid && eq_m_ready) begin
            if (eq_q.size() == 0) chk("eq_extra_beat", 64'h1, 64'h0);
            else begin
                eq_e = eq_q.pop_front();
                chk("eq_data", eq_m_data, eq_e.data);
                chk("eq_keep", 64'(eq_m_keep), 64'(eq_e.keep));
                chk("eq_last", 64'(eq_m_last), 64'(eq_e.last));
                chk("eq_user", 64'(eq_m_user), 64'(eq_e.user));
            end
        end
    end

    // ---------------- upsize driver with reference packing model
    logic [31:0] up_acc_d = '0;
    logic [3:0]  up_acc_k = '0;
    int          up_cnt   = 0;

    task automatic up_send(input logic [7:0] d, input logic l, input logic u);
        int t;
        up_s_data = d; up_s_last = l; up_s_user = u; up_s_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!up_s_ready && t < 200) begin @(negedge clk); t++; end
        if (!up_s_ready) chk("up_s_ready_timeout", 64'h0, 64'h1);
        @(posedge clk); #1;
        up_s_valid = 1'b0;
        up_acc_d[8*up_cnt +: 8] = d;
        up_acc_k[up_cnt] = 1'b1;
        up_cnt++;
        if (up_cnt == 4 || l) begin
            up_q.push_back('{data: 64'(up_acc_d), keep: 8'(up_acc_k), last: l, user: 2'(u)});
            up_acc_d = '0; up_acc_k = '0; up_cnt = 0;
        end
    endtask

    // ---------------- downsize driver with reference splitting model
    task automatic dn_send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        int t, top;
        dn_s_data = d; dn_s_keep = k; dn_s_last = l; dn_s_user = u; dn_s_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!dn_s_ready && t < 200) begin @(negedge clk); t++; end
        if (!dn_s_ready) chk("dn_s_ready_timeout", 64'h0, 64'h1);
        @(posedge clk); #1;
        dn_s_valid = 1'b0;
        top = 0;
        for (int i = 0; i < 4; i++) if (k[i]) top = i;
        if (k != 4'h0 || l)
            for (int i = 0; i <= top; i++)
                dn_q.push_back('{data: 64'(d[8*i +: 8]), keep: 8'(k[i]), last: l && (i == top), user: 2'(u)});
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((up_q.size() + dn_q.size() + eq_q.size()) != 0 && t < 300) begin @(negedge clk); t++; end
        chk(tag, 64'(up_q.size() + dn_q.size() + eq_q.size()), 64'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic xf;
        int   n_eq;
        up_s_data = '0; up_s_keep = 1'b1; up_s_valid = 0; up_s_last = 0; up_s_user = '0; up_m_ready = 1;
        dn_s_data = '0; dn_s_keep = '0;   dn_s_valid = 0; dn_s_last = 0; dn_s_user = '0; dn_m_ready = 1;
        eq_s_data = '0; eq_s_keep = '0;   eq_s_valid = 0; eq_s_last = 0; eq_s_user = '0; eq_m_ready = 1;
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
        id_s_data = '0; id_s_keep = 1'b1; id_s_valid = 0; id_s_last = 0; id_s_user = '0; id_m_ready = 1;
        id_s_tid = '0;  id_s_tdest = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_up_valid", 64'(up_m_valid), 64'h0);
        chk("rst_dn_valid", 64'(dn_m_valid), 64'h0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_up_ready", 64'(up_s_ready), 64'h1);
        chk("rst_dn_ready", 64'(dn_s_ready), 64'h1);

        // Upsize: full group, registered one cycle after the last byte
        up_send(8'h11, 0, 0); up_send(8'h22, 0, 0); up_send(8'h33, 0, 0);
        chk("up_not_early", 64'(up_m_valid), 64'h0);
        up_send(8'h44, 1, 1);
        chk("up_latency", 64'(up_m_valid), 64'h1);
        chk("up_full_word", 64'(up_m_data), 64'h44332211);
        // Short frame: unfilled lanes zero
        up_send(8'hAA, 0, 0); up_send(8'hBB, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        // Backpressure: beat held, three bytes buffered, fourth must stall
        up_m_ready = 1'b0;
        up_send(8'h01, 0, 0); up_send(8'h02, 0, 0); up_send(8'h03, 0, 0); up_send(8'h04, 0, 0);
        up_send(8'h05, 0, 1); up_send(8'h06, 0, 1); up_send(8'h07, 0, 1);
        up_s_data = 8'h08; up_s_last = 1'b1; up_s_user = 1'b1; up_s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("up_bp_ready", 64'(up_s_ready), 64'h0);
            chk("up_bp_valid", 64'(up_m_valid), 64'h1);
            chk("up_bp_hold", 64'(up_m_data), 64'h04030201);
        end
        @(posedge clk); #1;
        up_m_ready = 1'b1;
        up_send(8'h08, 1, 1);
        drain("up_drain");

        // Downsize: trailing empty segment suppressed, ready back on the final segment
        dn_send(32'hDDCCBBAA, 4'h7, 1, 1);
        @(negedge clk);
        chk("dn_busy_ready", 64'(dn_s_ready), 64'h0);
        @(negedge clk);
        @(negedge clk);
        chk("dn_final_ready", 64'(dn_s_ready), 64'h1);
        chk("dn_final_data", 64'(dn_m_data), 64'hCC);
        dn_send(32'h12345678, 4'h0, 0, 0);
        dn_send(32'h9ABCDEF0, 4'h0, 1, 0);
        dn_send(32'h87654321, 4'hF, 1, 0);
        dn_send(32'h00550000, 4'h4, 0, 1);
        drain("dn_drain");
        // Backpressure on the narrow side
        dn_m_ready = 1'b0;
        dn_send(32'h44332211, 4'hF, 0, 1);
        dn_s_data = 32'h88776655; dn_s_keep = 4'hF; dn_s_last = 1'b1; dn_s_user = 1'b0; dn_s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("dn_bp_ready", 64'(dn_s_ready), 64'h0);
            chk("dn_bp_valid", 64'(dn_m_valid), 64'h1);
            chk("dn_bp_hold", 64'(dn_m_data), 64'h11);
        end
        @(posedge clk); #1;
        dn_m_ready = 1'b1;
        dn_send(32'h88776655, 4'hF, 1, 0);
        drain("dn_bp_drain");

        // Reset in the middle of a held downsize word
        dn_m_ready = 1'b0;
        dn_send(32'hCAFEF00D, 4'hF, 1, 0);
        #2 rst = 1'b0;
        #1;
        chk("dn_rst_valid", 64'(dn_m_valid), 64'h0);
        dn_q.delete();
        @(negedge clk) rst = 1'b1;
        dn_m_ready = 1'b1;
        @(posedge clk); #1;
        chk("dn_post_rst_valid", 64'(dn_m_valid), 64'h0);
        chk("dn_post_rst_ready", 64'(dn_s_ready), 64'h1);
        dn_send(32'h000000BE, 4'h1, 1, 1);
        dn_send(32'h00002301, 4'h3, 1, 0);
        drain("dn_rst_drain");

        // Pass-through: random frames with random stalls
        n_eq = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            xf = eq_s_valid && eq_m_ready;
            @(posedge clk); #1;
            if (!eq_s_valid || xf) begin
                if (n_eq < 30 && $urandom_range(0, 3) != 0) begin
                    eq_s_data  = {$urandom, $urandom};
                    eq_s_keep  = 8'($urandom);
                    eq_s_last  = ($urandom_range(0, 3) == 0);
                    eq_s_user  = 2'($urandom);
                    eq_s_valid = 1'b1;
                    eq_q.push_back('{data: eq_s_data, keep: eq_s_keep, last: eq_s_last, user: eq_s_user});
                    n_eq++;
                end else begin
                    eq_s_valid = 1'b0;
                end
            end
            eq_m_ready = ($urandom_range(0, 3) != 0);
            if (n_eq == 30 && !eq_s_valid) break;
        end
        eq_s_valid = 1'b0;
        eq_m_ready = 1'b1;
        chk("eq_sent", 64'(n_eq), 64'd30);
        drain("eq_drain");

`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
        // Upsize sideband follows the first byte of the group
        id_s_data = 8'h01; id_s_tid = 8'd3; id_s_tdest = 8'd7; id_s_last = 1'b0; id_s_valid = 1'b1;
        @(negedge clk);
        chk("id_ready0", 64'(id_s_ready), 64'h1);
        @(posedge clk); #1;
        id_s_data = 8'h02; id_s_tid = 8'd5; id_s_tdest = 8'd9; id_s_last = 1'b1;
        @(negedge clk);
        chk("id_ready1", 64'(id_s_ready), 64'h1);
        @(posedge clk); #1;
        id_s_valid = 1'b0;
        chk("id_valid", 64'(id_m_valid), 64'h1);
        chk("id_data", 64'(id_m_data), 64'h0201);
        chk("id_tid", 64'(id_m_tid), 64'd3);
        chk("id_tdest", 64'(id_m_tdest), 64'd7);
        @(posedge clk); #1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
